// File: rtl/bunny_hit_gen.sv
// Collision-to-hit generator: turns bunny/obstacle overlap into single-cycle hit
// pulses, then runs a blinking invulnerability window before re-arming.
module bunny_hit_gen #(
  parameter int INVULN_CYCLES = 50_000_000,
  parameter int BLINK_CYCLES  = 6_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bunny_lane,
  input  logic       bunny_air,
  input  logic       obs_valid,
  input  logic [1:0] obs_lane,
  input  logic       obs_at_bunny,
  input  logic       die,
  output logic       hit,
  output logic       invuln,
  output logic       blink
);

  localparam int WW = $clog2(INVULN_CYCLES);
  // A single-cycle blink period still needs a one-bit counter to compare against.
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [WW-1:0] WIN_LAST = WW'(INVULN_CYCLES - 1);
  localparam logic [WW-1:0] WIN_ONE  = WW'(1);
  localparam logic [WW-1:0] WIN_ZERO = WW'(0);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] BLK_ONE  = BW'(1);
  localparam logic [BW-1:0] BLK_ZERO = BW'(0);

  typedef enum logic [1:0] {
    ARMED      = 2'd0,
    INVULN     = 2'd1,
    WAIT_CLEAR = 2'd2,
    DEAD       = 2'd3
  } state_t;

  state_t        state_r;
  logic [WW-1:0] win_cnt_r;
  logic [BW-1:0] blink_cnt_r;
  logic          ov_s;

  // Ground-level bunny sharing lane and column with a live obstacle.
  always_comb begin
    ov_s = obs_valid & obs_at_bunny & (obs_lane == bunny_lane) & ~bunny_air;
  end

  // Hit/invulnerability state machine with registered outputs and window counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ARMED;
      hit         <= 1'b0;
      invuln      <= 1'b0;
      blink       <= 1'b1;
      win_cnt_r   <= WIN_ZERO;
      blink_cnt_r <= BLK_ZERO;
    end else if (die) begin
      state_r     <= DEAD;
      hit         <= 1'b0;
      invuln      <= 1'b0;
      blink       <= 1'b1;
      win_cnt_r   <= WIN_ZERO;
      blink_cnt_r <= BLK_ZERO;
    end else begin
      case (state_r)
        ARMED: begin
          win_cnt_r   <= WIN_ZERO;
          blink_cnt_r <= BLK_ZERO;
          if (ov_s) begin
            state_r <= INVULN;
            hit     <= 1'b1;
            invuln  <= 1'b1;
            blink   <= 1'b0;
          end else begin
            state_r <= ARMED;
            hit     <= 1'b0;
            invuln  <= 1'b0;
            blink   <= 1'b1;
          end
        end
        INVULN: begin
          hit <= 1'b0;
          if (win_cnt_r == WIN_LAST) begin
            // Overlap still present at window end must clear before re-arming.
            state_r     <= ov_s ? WAIT_CLEAR : ARMED;
            invuln      <= 1'b0;
            blink       <= 1'b1;
            win_cnt_r   <= WIN_ZERO;
            blink_cnt_r <= BLK_ZERO;
          end else begin
            state_r   <= INVULN;
            invuln    <= 1'b1;
            win_cnt_r <= win_cnt_r + WIN_ONE;
            if (blink_cnt_r == BLK_LAST) begin
              blink_cnt_r <= BLK_ZERO;
              blink       <= ~blink;
            end else begin
              blink_cnt_r <= blink_cnt_r + BLK_ONE;
              blink       <= blink;
            end
          end
        end
        WAIT_CLEAR: begin
          hit         <= 1'b0;
          invuln      <= 1'b0;
          blink       <= 1'b1;
          win_cnt_r   <= WIN_ZERO;
          blink_cnt_r <= BLK_ZERO;
          if (!ov_s) begin
            state_r <= ARMED;
          end else begin
            state_r <= WAIT_CLEAR;
          end
        end
        DEAD: begin
          state_r     <= DEAD;
          hit         <= 1'b0;
          invuln      <= 1'b0;
          blink       <= 1'b1;
          win_cnt_r   <= WIN_ZERO;
          blink_cnt_r <= BLK_ZERO;
        end
        default: begin
          state_r     <= ARMED;
          hit         <= 1'b0;
          invuln      <= 1'b0;
          blink       <= 1'b1;
          win_cnt_r   <= WIN_ZERO;
          blink_cnt_r <= BLK_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bunny_hit_gen.sv
// Directed bench for bunny_hit_gen: per-cycle comparison against a timestamp-based
// model of the hit/window rules, plus literal checks of the test-plan scenarios.
module tb_bunny_hit_gen;

  localparam int INV = 8;
  localparam int BLK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] bunny_lane;
  logic       bunny_air;
  logic       obs_valid;
  logic [1:0] obs_lane;
  logic       obs_at_bunny;
  logic       die;
  logic       die_man;
  logic       hit, invuln, blink;

  int tests = 0;
  int fails = 0;
  int dut_hits = 0;
  int h0;
  bit chk_en = 1'b0;

  // Life counter stand-in: three lives, die once they are spent.
  bit lc_en = 1'b0;
  bit lc_load = 1'b0;
  int lives = 3;

  assign die = die_man | (lc_en && (lives == 0));

  bunny_hit_gen #(.INVULN_CYCLES(INV), .BLINK_CYCLES(BLK)) dut (
    .clk(clk), .rst(rst), .bunny_lane(bunny_lane), .bunny_air(bunny_air),
    .obs_valid(obs_valid), .obs_lane(obs_lane), .obs_at_bunny(obs_at_bunny),
    .die(die), .hit(hit), .invuln(invuln), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lc_load) lives <= 3;
    else if (hit === 1'b1 && lives != 0) lives <= lives - 1;
  end

  // Model: outputs follow from cycles elapsed since the last hit.
  logic exp_hit = 1'b0, exp_inv = 1'b0, exp_blink = 1'b1;
  bit   m_dead = 1'b0, m_block = 1'b0;
  int   m_hit_t = -1000;
  int   m_cyc = 0;
  int   k, newc;
  logic ovm;

  always @(posedge clk) begin
    ovm  = obs_valid && obs_at_bunny && (obs_lane == bunny_lane) && !bunny_air;
    newc = m_cyc + 1;
    k    = newc - m_hit_t;
    m_cyc <= newc;
    if (rst) begin
      m_dead <= 1'b0; m_block <= 1'b0; m_hit_t <= -1000;
      exp_hit <= 1'b0; exp_inv <= 1'b0; exp_blink <= 1'b1;
    end else if (m_dead || die) begin
      m_dead <= 1'b1;
      exp_hit <= 1'b0; exp_inv <= 1'b0; exp_blink <= 1'b1;
    end else if (k >= 1 && k < INV) begin
      exp_hit <= 1'b0; exp_inv <= 1'b1; exp_blink <= ((k / BLK) % 2) == 1;
    end else if (k == INV) begin
      m_block <= ovm;
      exp_hit <= 1'b0; exp_inv <= 1'b0; exp_blink <= 1'b1;
    end else if (m_block) begin
      if (!ovm) m_block <= 1'b0;
      exp_hit <= 1'b0; exp_inv <= 1'b0; exp_blink <= 1'b1;
    end else if (ovm) begin
      m_hit_t <= newc;
      exp_hit <= 1'b1; exp_inv <= 1'b1; exp_blink <= 1'b0;
    end else begin
      exp_hit <= 1'b0; exp_inv <= 1'b0; exp_blink <= 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (hit === 1'b1) dut_hits++;
    if (chk_en) begin
      check("cyc_hit", int'(hit), int'(exp_hit));
      check("cyc_invuln", int'(invuln), int'(exp_inv));
      check("cyc_blink", int'(blink), int'(exp_blink));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  bit inv_seq [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit blk_seq [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; bunny_lane = 2'd1; obs_lane = 2'd1; obs_valid = 1'b0;
    obs_at_bunny = 1'b1; bunny_air = 1'b0; die_man = 1'b0;
    tick(1);
    chk_en = 1'b1;

    // Reset held with overlap present
    obs_valid = 1'b1;
    tick(3);
    check("rst_hit", int'(hit), 0);
    check("rst_invuln", int'(invuln), 0);
    check("rst_blink", int'(blink), 1);
    h0 = dut_hits;
    rst = 1'b0;
    tick(1);
    check("rel_hit", int'(hit), 1);
    check("rel_invuln", int'(invuln), 1);
    obs_valid = 1'b0;
    tick(12);
    check("rel_count", dut_hits - h0, 1);

    // Single one-cycle overlap: window shape
    h0 = dut_hits;
    obs_valid = 1'b1;
    tick(1);
    obs_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("seq_hit[%0d]", i), int'(hit), int'(i == 0));
      check($sformatf("seq_invuln[%0d]", i), int'(invuln), int'(inv_seq[i]));
      check($sformatf("seq_blink[%0d]", i), int'(blink), int'(blk_seq[i]));
      tick(1);
    end
    tick(3);
    check("single_count", dut_hits - h0, 1);

    // Sustained overlap, then drop for one cycle and re-hit
    h0 = dut_hits;
    obs_valid = 1'b1;
    tick(30);
    check("sustain_count", dut_hits - h0, 1);
    check("sustain_invuln", int'(invuln), 0);
    check("sustain_blink", int'(blink), 1);
    obs_valid = 1'b0;
    tick(1);
    obs_valid = 1'b1;
    tick(1);
    check("rearm_hit", int'(hit), 1);
    obs_valid = 1'b0;
    tick(12);
    check("rearm_count", dut_hits - h0, 2);

    // Each overlap term missing in turn
    for (int c = 0; c < 3; c++) begin
      h0 = dut_hits;
      if (c == 0) obs_lane = 2'd2;
      else if (c == 1) bunny_air = 1'b1;
      else obs_at_bunny = 1'b0;
      obs_valid = 1'b1;
      tick(4);
      check($sformatf("suppress_%0d", c), dut_hits - h0, 0);
      obs_valid = 1'b0; obs_lane = 2'd1; bunny_air = 1'b0; obs_at_bunny = 1'b1;
      tick(1);
    end
    bunny_lane = 2'd3; obs_lane = 2'd3; obs_valid = 1'b1;
    tick(1);
    check("lane3_hit", int'(hit), 1);
    obs_valid = 1'b0; bunny_lane = 2'd1; obs_lane = 2'd1;
    tick(12);

    // Three hits drain the lives; further overlap is ignored
    lc_load = 1'b1;
    tick(1);
    lc_load = 1'b0; lc_en = 1'b1;
    h0 = dut_hits;
    for (int n = 0; n < 3; n++) begin
      obs_valid = 1'b1;
      tick(1);
      obs_valid = 1'b0;
      tick(12);
    end
    obs_valid = 1'b1;
    tick(20);
    check("three_count", dut_hits - h0, 3);
    check("dead_invuln", int'(invuln), 0);
    check("dead_blink", int'(blink), 1);
    obs_valid = 1'b0; lc_en = 1'b0; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);

    // die and overlap together in ARMED
    h0 = dut_hits;
    die_man = 1'b1; obs_valid = 1'b1;
    tick(1);
    check("die_ov_hit", int'(hit), 0);
    check("die_ov_invuln", int'(invuln), 0);
    check("die_ov_blink", int'(blink), 1);
    die_man = 1'b0;
    tick(5);
    check("die_ov_count", dut_hits - h0, 0);
    obs_valid = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0; obs_valid = 1'b1;
    tick(1);
    check("post_dead_hit", int'(hit), 1);
    obs_valid = 1'b0;

    // die in the middle of the window
    tick(3);
    check("mid_invuln_pre", int'(invuln), 1);
    h0 = dut_hits;
    die_man = 1'b1;
    tick(1);
    check("mid_die_invuln", int'(invuln), 0);
    check("mid_die_blink", int'(blink), 1);
    die_man = 1'b0; obs_valid = 1'b1;
    tick(12);
    check("mid_die_count", dut_hits - h0, 0);
    obs_valid = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
